fasttwosum_tree_scheduler: RTL and testbench

Shares one pipelined FastTwoSum adder tree among `NUM_REQ` requesters. Each requester submits a job: a stream of `ELEMS_COUNT`-wide beats terminated by `last`. The scheduler grants one job at a time with round-robin arbitration, feeds its beats into the tree and tracks in-flight beats with a latency-matched token pipe. It accumulates the per-beat tree sums into one result per job and returns it through a valid/ready port. It sits between the requesting compute units and the tree instance, which is instantiated beside it.

---
 rtl/fasttwosum_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/fasttwosum_tree_scheduler.sv | 147 ++++++++++++++
 tb/tb_fasttwosum_tree_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fasttwosum_sched_pkg.sv
// rtl/fasttwosum_sched_pkg.sv - shared types for the FastTwoSum tree scheduler
package fasttwosum_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    OUT
  } state_e;

  // One token per tree input slot; travels alongside the beat through the tree latency
  typedef struct packed {
    logic valid;
    logic last;
  } token_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts at i_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_k;

  // Walk from the farthest offset down to the pointer so the nearest request wins last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[w_k]) begin
        o_gnt      = '0;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fasttwosum_tree_scheduler.sv
// rtl/fasttwosum_tree_scheduler.sv - round-robin job scheduler in front of a shared pipelined adder tree
module fasttwosum_tree_scheduler
  import fasttwosum_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ELEMS_COUNT  = 32,
  parameter int BIT_WIDTH_I  = 8,
  parameter int SUM_WIDTH    = BIT_WIDTH_I + $clog2(ELEMS_COUNT),
  parameter int TREE_LATENCY = 8,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_REQ-1:0]                         req_valid_i,
  output logic [NUM_REQ-1:0]                         req_ready_o,
  input  logic [NUM_REQ*ELEMS_COUNT*BIT_WIDTH_I-1:0] req_vec_i,
  input  logic [NUM_REQ-1:0]                         req_last_i,
  output logic [ELEMS_COUNT*BIT_WIDTH_I-1:0]         tree_vec_o,
  input  logic [SUM_WIDTH-1:0]                       tree_sum_i,
  output logic                                       res_valid_o,
  input  logic                                       res_ready_i,
  output logic [ACC_WIDTH-1:0]                       res_sum_o,
  output logic [$clog2(NUM_REQ)-1:0]                 res_id_o,
  output logic                                       res_ovf_o,
  output logic                                       busy_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int VEC_W = ELEMS_COUNT * BIT_WIDTH_I;
  localparam int DEPTH = TREE_LATENCY + 1;

  state_e                r_state;
  logic [ID_W-1:0]       r_gnt_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic [VEC_W-1:0]      r_tree_vec;
  token_t                r_pipe [DEPTH];
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_ovf;
  logic                  r_res_valid;
  logic                  r_done;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_gnt_idx;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_acc_last;
  logic [VEC_W-1:0]      w_acc_vec;
  token_t                w_exit;
  logic [ACC_WIDTH-1:0]  w_sum_ext;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;
  logic                  w_add_ovf;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req (req_valid_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // Ready is only ever set for the granted requester while streaming
  assign w_accept   = |(req_valid_i & r_req_ready);
  assign w_acc_last = req_last_i[r_gnt_id];
  assign w_acc_vec  = req_vec_i[int'(r_gnt_id)*VEC_W +: VEC_W];
  assign w_exit     = r_pipe[DEPTH-1];
  assign w_sum_ext  = ACC_WIDTH'($signed(tree_sum_i));
  assign w_acc_nxt  = r_acc + w_sum_ext;
  assign w_add_ovf  = (r_acc[ACC_WIDTH-1] == w_sum_ext[ACC_WIDTH-1]) &&
                      (w_acc_nxt[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0].valid <= w_accept;
      r_pipe[0].last  <= w_accept & w_acc_last;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_req_ready <= '0;
      r_tree_vec  <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tree_vec <= w_accept ? w_acc_vec : '0;
      if (w_exit.valid) begin
        r_acc <= w_acc_nxt;
        if (w_add_ovf)   r_ovf  <= 1'b1;
        if (w_exit.last) r_done <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_id    <= w_gnt_idx;
            r_req_ready <= w_gnt;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept && w_acc_last) begin
            r_req_ready <= '0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          // r_done lands on the edge the last sum is added, so the result is final here
          if (r_done) begin
            r_res_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign tree_vec_o  = r_tree_vec;
  assign res_valid_o = r_res_valid;
  assign res_sum_o   = r_acc;
  assign res_id_o    = r_gnt_id;
  assign res_ovf_o   = r_ovf;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_fasttwosum_tree_scheduler.sv
// tb/tb_fasttwosum_tree_scheduler.sv - directed self-checking bench for fasttwosum_tree_scheduler
module tb_fasttwosum_tree_scheduler;

  localparam int NR = 4;
  localparam int EC = 32;
  localparam int BW = 8;
  localparam int SW = BW + $clog2(EC);
  localparam int L  = 8;
  localparam int AW = 24;
  localparam int AW14 = 14;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [NR*EC*BW-1:0]  req_vec_i;
  logic [NR-1:0]        req_last_i;
  logic [EC*BW-1:0]     tree_vec_o;
  logic [SW-1:0]        tree_sum_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [AW-1:0]        res_sum_o;
  logic [1:0]           res_id_o;
  logic                 res_ovf_o;
  logic                 busy_o;

  logic [NR-1:0]        req_ready_14;
  logic [EC*BW-1:0]     tree_vec_14;
  logic                 res_valid_14;
  logic [AW14-1:0]      res_sum_14;
  logic [1:0]           res_id_14;
  logic                 res_ovf_14;
  logic                 busy_14;

  int checks = 0;
  int failures = 0;
  int n_accepted = 0;
  int n;

  always #5 clk = ~clk;

  fasttwosum_tree_scheduler #(
    .NUM_REQ(NR), .ELEMS_COUNT(EC), .BIT_WIDTH_I(BW), .SUM_WIDTH(SW),
    .TREE_LATENCY(L), .ACC_WIDTH(AW)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vec_i(req_vec_i), .req_last_i(req_last_i), .tree_vec_o(tree_vec_o),
    .tree_sum_i(tree_sum_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_sum_o(res_sum_o), .res_id_o(res_id_o), .res_ovf_o(res_ovf_o), .busy_o(busy_o)
  );

  fasttwosum_tree_scheduler #(
    .NUM_REQ(NR), .ELEMS_COUNT(EC), .BIT_WIDTH_I(BW), .SUM_WIDTH(SW),
    .TREE_LATENCY(L), .ACC_WIDTH(AW14)
  ) u_dut14 (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_14),
    .req_vec_i(req_vec_i), .req_last_i(req_last_i), .tree_vec_o(tree_vec_14),
    .tree_sum_i(tree_sum_i), .res_valid_o(res_valid_14), .res_ready_i(res_ready_i),
    .res_sum_o(res_sum_14), .res_id_o(res_id_14), .res_ovf_o(res_ovf_14), .busy_o(busy_14)
  );

  // Reference adder tree: samples tree_vec_o, sum usable at the accumulate edge
  logic [SW-1:0] tb_d [L];

  function automatic int vec_sum(input logic [EC*BW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < EC; k++) s = s + int'($signed(v[k*BW +: BW]));
    return s;
  endfunction

  always @(posedge clk) begin
    tb_d[0] <= SW'(vec_sum(tree_vec_o));
    for (int i = 1; i < L; i++) tb_d[i] <= tb_d[i-1];
  end
  assign tree_sum_i = tb_d[L-1];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NR-1:0] hs;
    hs = req_valid_i & req_ready_o;
    @(negedge clk);
    n_accepted = n_accepted + $countones(hs);
    req_valid_i = req_valid_i & ~hs;
  endtask

  task automatic set_beat(input int id, input int e0, input int fill, input logic last);
    logic [BW-1:0] v;
    for (int k = 0; k < EC; k++) begin
      v = (k == 0) ? e0[BW-1:0] : fill[BW-1:0];
      req_vec_i[(id*EC + k)*BW +: BW] = v;
    end
    req_last_i[id] = last;
  endtask

  task automatic send_beat(input int id, input int e0, input int fill, input logic last);
    int w;
    set_beat(id, e0, fill, last);
    req_valid_i[id] = 1'b1;
    w = 0;
    while (!req_ready_o[id] && w < 60) begin
      tick();
      w++;
    end
    if (w >= 60) chk("beat_grant_timeout", req_ready_o[id], 1);
    tick();
  endtask

  task automatic wait_result(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!res_valid_o && cnt < 200);
    chk("res_valid_seen", res_valid_o, 1);
  endtask

  task automatic check_reset();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_tree_vec", |tree_vec_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_sum", res_sum_o, 0);
    chk("rst_res_id", res_id_o, 0);
    chk("rst_res_ovf", res_ovf_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_res_sum14", res_sum_14, 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_vec_i   = '0;
    req_last_i  = '0;
    res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst_ni = 1'b1;
    @(negedge clk);

    // All four request together from rr_ptr=0: served 0,1,2,3
    for (int j = 0; j < NR; j++) set_beat(j, 10 * (j + 1), 0, 1'b1);
    req_valid_i = '1;
    for (int k = 0; k < NR; k++) begin
      wait_result(n);
      chk("rr_id", res_id_o, k);
      chk("rr_sum", $signed(res_sum_o), 10 * (k + 1));
      tick();
    end

    // Single beat of all +1: result 11 edges after the request is sampled
    send_beat(0, 1, 1, 1'b1);
    n = 2;
    begin
      int m;
      wait_result(m);
      n = n + m;
    end
    chk("single_latency", n - 1, 11);
    chk("single_sum", $signed(res_sum_o), 32);
    chk("single_id", res_id_o, 0);
    tick();

    // Requester 2: three beats 100, -40, 7 with a two-cycle bubble
    n_accepted = 0;
    send_beat(2, 100, 0, 1'b0);
    tick();
    tick();
    send_beat(2, -40, 0, 1'b0);
    send_beat(2, 7, 0, 1'b1);
    wait_result(n);
    chk("multi_sum", $signed(res_sum_o), 67);
    chk("multi_ovf", res_ovf_o, 0);
    chk("multi_id", res_id_o, 2);
    chk("multi_beats", n_accepted, 3);
    tick();

    // Result stall with another requester pending
    res_ready_i = 1'b0;
    set_beat(1, 9, 0, 1'b1);
    req_valid_i[1] = 1'b1;
    send_beat(3, -5, 0, 1'b1);
    wait_result(n);
    chk("stall_id", res_id_o, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", res_valid_o, 1);
      chk("stall_sum", $signed(res_sum_o), -5);
      chk("stall_ready", req_ready_o, 0);
    end
    res_ready_i = 1'b1;
    tick();
    chk("stall_release_valid", res_valid_o, 0);
    chk("stall_release_busy", busy_o, 0);
    wait_result(n);
    chk("after_stall_id", res_id_o, 1);
    chk("after_stall_sum", $signed(res_sum_o), 9);
    tick();

    // 4064 + 4064 + 64 = 8192: wraps in the 14-bit instance only
    send_beat(0, 127, 127, 1'b0);
    send_beat(0, 127, 127, 1'b0);
    send_beat(0, 64, 0, 1'b1);
    wait_result(n);
    chk("ovf24_sum", $signed(res_sum_o), 8192);
    chk("ovf24_flag", res_ovf_o, 0);
    chk("ovf14_valid", res_valid_14, 1);
    chk("ovf14_sum", $signed(res_sum_14), -8192);
    chk("ovf14_flag", res_ovf_14, 1);
    tick();

    // Reset while draining discards the partial job
    send_beat(1, 50, 0, 1'b1);
    tick();
    tick();
    chk("drain_busy", busy_o, 1);
    chk("drain_ready", req_ready_o, 0);
    rst_ni = 1'b0;
    #1;
    check_reset();
    tick();
    tick();
    rst_ni = 1'b1;
    send_beat(1, 3, 0, 1'b1);
    wait_result(n);
    chk("post_rst_id", res_id_o, 1);
    chk("post_rst_sum", $signed(res_sum_o), 3);
    chk("post_rst_sum14", $signed(res_sum_14), 3);
    tick();
    chk("final_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
